// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue stage: ALU op codes, RV32I
// opcodes, branch kinds and the decoder output record.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_kind_e;

  typedef enum logic [1:0] {SEL_A_ZERO, SEL_A_RS1, SEL_A_PC} sel_a_e;
  typedef enum logic [1:0] {SEL_B_ZERO, SEL_B_RS2, SEL_B_IMM} sel_b_e;

  typedef struct packed {
    sel_a_e     sel_a;
    sel_b_e     sel_b;
    logic [3:0] alu_op;
    logic       branch;
    br_kind_e   br_kind;
    logic       illegal;
  } dec_t;

  // Branch condition from the ALU outputs; SLT/SLTU report their answer in bit 0.
  function automatic logic resolve_taken(input br_kind_e kind, input logic zero,
                                         input logic lsb);
    case (kind)
      BR_EQ:         return zero;
      BR_NE:         return !zero;
      BR_LT, BR_LTU: return lsb;
      BR_GE, BR_GEU: return !lsb;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode: opcode/funct fields to operand selects, ALU op,
// branch kind and illegal flag.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output dec_t       dec
);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // leaves an output unassigned and infers a latch.
    dec         = '0;
    dec.sel_a   = SEL_A_ZERO;
    dec.sel_b   = SEL_B_ZERO;
    dec.alu_op  = ALU_ADD;
    dec.br_kind = BR_NONE;

    case (opcode)
      OPC_OP: begin
        dec.sel_a = SEL_A_RS1;
        dec.sel_b = SEL_B_RS2;
        if (funct7b5 && !(funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          // SRL sits at 1001 in the shared encoding, so shifts pick by b5.
          dec.alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
        end else begin
          dec.alu_op = {funct7b5, funct3};
        end
      end
      OPC_OP_IMM: begin
        dec.sel_a = SEL_A_RS1;
        dec.sel_b = SEL_B_IMM;
        if (funct3 == 3'b101) dec.alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
        else                  dec.alu_op = {1'b0, funct3};
        dec.illegal = (funct3 == 3'b001) && funct7b5;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec.sel_a = SEL_A_RS1;
        dec.sel_b = SEL_B_IMM;
      end
      OPC_LUI: begin
        dec.sel_b = SEL_B_IMM;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec.sel_a = SEL_A_PC;
        dec.sel_b = SEL_B_IMM;
      end
      OPC_BRANCH: begin
        dec.sel_a  = SEL_A_RS1;
        dec.sel_b  = SEL_B_RS2;
        dec.branch = 1'b1;
        case (funct3)
          3'b000: begin dec.alu_op = ALU_SUB;  dec.br_kind = BR_EQ;  end
          3'b001: begin dec.alu_op = ALU_SUB;  dec.br_kind = BR_NE;  end
          3'b100: begin dec.alu_op = ALU_SLT;  dec.br_kind = BR_LT;  end
          3'b101: begin dec.alu_op = ALU_SLT;  dec.br_kind = BR_GE;  end
          3'b110: begin dec.alu_op = ALU_SLTU; dec.br_kind = BR_LTU; end
          3'b111: begin dec.alu_op = ALU_SLTU; dec.br_kind = BR_GEU; end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready front end for the ALU: S1 holds decoded operands that
// feed the ALU, S2 captures the ALU result and resolved branch outcome.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [6:0]  iOpcode,
  input  logic [2:0]  iFunct3,
  input  logic        iFunct7b5,
  input  logic [31:0] iPc,
  input  logic [31:0] iRs1Data,
  input  logic [31:0] iRs2Data,
  input  logic [31:0] iImm,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [3:0]  oAluOp,
  input  logic [31:0] iAluData,
  input  logic        iAluZero,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oResult,
  output logic        oBranch,
  output logic        oTaken,
  output logic        oIllegal
);

  dec_t        dec;
  logic [31:0] a_next;
  logic [31:0] b_next;

  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [3:0]  s1_op;
  logic        s1_branch;
  br_kind_e    s1_br_kind;
  logic        s1_illegal;

  logic        s2_valid;
  logic [31:0] s2_result;
  logic        s2_branch;
  logic        s2_taken;
  logic        s2_illegal;

  logic        s1_adv;
  logic        s2_adv;

  alu_op_decoder u_decoder (
    .opcode   (iOpcode),
    .funct3   (iFunct3),
    .funct7b5 (iFunct7b5),
    .dec      (dec)
  );

  always_comb begin
    a_next = '0;
    b_next = '0;
    case (dec.sel_a)
      SEL_A_RS1: a_next = iRs1Data;
      SEL_A_PC:  a_next = iPc;
      default:   a_next = '0;
    endcase
    case (dec.sel_b)
      SEL_B_RS2: b_next = iRs2Data;
      SEL_B_IMM: b_next = iImm;
      default:   b_next = '0;
    endcase
  end

  assign s2_adv = !s2_valid || iReady;
  assign s1_adv = !s1_valid || s2_adv;
  assign oReady = s1_adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= ALU_ADD;
      s1_branch  <= 1'b0;
      s1_br_kind <= BR_NONE;
      s1_illegal <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= iValid;
      if (iValid) begin
        s1_a       <= a_next;
        s1_b       <= b_next;
        s1_op      <= dec.alu_op;
        s1_branch  <= dec.branch;
        s1_br_kind <= dec.br_kind;
        s1_illegal <= dec.illegal;
      end
    end
  end

  // Payload only loads alongside valid, so held outputs cannot glitch.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_branch  <= 1'b0;
      s2_taken   <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= iAluData;
        s2_branch  <= s1_branch;
        s2_taken   <= resolve_taken(s1_br_kind, iAluZero, iAluData[0]);
        s2_illegal <= s1_illegal;
      end
    end
  end

  assign oAluA    = s1_a;
  assign oAluB    = s1_b;
  assign oAluOp   = s1_op;
  assign oValid   = s2_valid;
  assign oResult  = s2_result;
  assign oBranch  = s2_branch;
  assign oTaken   = s2_taken;
  assign oIllegal = s2_illegal;

endmodule
